// File: rtl/noc_inject_arbiter_pkg.sv
// Shared definitions for the NoC injection arbiter: flit width, FSM states, watchdog default.
// The optional stall watchdog is enabled by defining NOC_ARB_WDOG_EN.
package noc_inject_arbiter_pkg;

  localparam int NOC_DATA_WIDTH       = 32;
  localparam int NOC_WDOG_CYC_DEFAULT = 1024;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  // Index reached by stepping 'off' places past 'ptr' on a ring of 'n' entries.
  function automatic int rr_wrap(input int ptr, input int off, input int n);
    return (ptr + off) % n;
  endfunction

endpackage

// File: rtl/noc_inject_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after ptr, wrapping.
module noc_rr_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  always_comb begin
    int j;
    j            = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    // ptr itself is visited last, so the previous owner has lowest priority
    for (int off = 1; off <= NUM_REQ; off++) begin
      j = rr_wrap(int'(ptr), off, NUM_REQ);
      if (!any && req[j]) begin
        any             = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-level round-robin arbiter multiplexing NUM_REQ flit sources onto one Noc_sender port.
// Define NOC_ARB_WDOG_EN to build the sticky LOCK-stall watchdog (wdog_err); otherwise it is tied 0.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = NOC_DATA_WIDTH,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int WDOG_CYC = NOC_WDOG_CYC_DEFAULT
) (
  input  logic                       noc_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_flit,
  input  logic [NUM_REQ-1:0]         req_is_header,
  input  logic [NUM_REQ-1:0]         req_is_tail,
  output logic                       Noc_sender_valid,
  input  logic                       Noc_sender_ready,
  output logic [DATA_W-1:0]          Noc_sender_flit,
  input  logic                       Noc_sender_VCready,
  output logic                       Noc_sender_is_header,
  output logic                       Noc_sender_is_tail,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy,
  output logic                       wdog_err
);

  arb_state_e          state_reg, state_next;
  logic [ID_W-1:0]     grant_reg, grant_next;
  logic [NUM_REQ-1:0]  owner_mask_reg, owner_mask_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;

  logic [DATA_W-1:0]   flit_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                lock;
  logic                xfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
      assign flit_arr[gi]  = req_flit[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = owner_mask_reg[gi] & lock & Noc_sender_ready;
    end
  endgenerate

  // Only a header may open a packet; stray body flits wait until their source is granted.
  assign cand = req_valid & req_is_header;

  noc_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req          (cand),
    .ptr          (rr_ptr_reg),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick_idx),
    .any          (pick_any)
  );

  // Sender side is a pure mux of the registered owner, so it is all-zero outside LOCK.
  assign lock                 = (state_reg == ARB_LOCK);
  assign Noc_sender_valid     = lock & req_valid[grant_reg];
  assign Noc_sender_flit      = lock ? flit_arr[grant_reg] : '0;
  assign Noc_sender_is_header = lock & req_is_header[grant_reg];
  assign Noc_sender_is_tail   = lock & req_is_tail[grant_reg];
  assign xfer                 = Noc_sender_valid & Noc_sender_ready;
  assign grant_id             = grant_reg;
  assign busy                 = lock;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    owner_mask_next = owner_mask_reg;
    rr_ptr_next     = rr_ptr_reg;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_any && Noc_sender_VCready) begin
          grant_next      = pick_idx;
          owner_mask_next = pick_onehot;
          state_next      = ARB_LOCK;
        end
      end
      ARB_LOCK: begin
        // Credit was checked at the header; the rest of the packet flows regardless of VCready.
        if (xfer && req_is_tail[grant_reg]) begin
          rr_ptr_next     = grant_reg;
          owner_mask_next = '0;
          state_next      = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge noc_clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      grant_reg      <= '0;
      owner_mask_reg <= '0;
      rr_ptr_reg     <= ID_W'(NUM_REQ - 1);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      owner_mask_reg <= owner_mask_next;
      rr_ptr_reg     <= rr_ptr_next;
    end
  end

`ifdef NOC_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYC + 1);

  logic [CNT_W-1:0] wdog_cnt_reg;
  logic             wdog_err_reg;

  // Counts consecutive LOCK cycles without a transfer; the error only reports, never aborts.
  always_ff @(posedge noc_clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else if (!lock || xfer) begin
      wdog_cnt_reg <= '0;
    end else if (wdog_cnt_reg == CNT_W'(WDOG_CYC - 1)) begin
      wdog_err_reg <= 1'b1;
    end else begin
      wdog_cnt_reg <= wdog_cnt_reg + CNT_W'(1);
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Self-checking bench for noc_inject_arbiter: directed phases plus a randomized phase, checked
// against a packet-queue reference model. Define NOC_ARB_WDOG_EN to check the watchdog build.
module tb_noc_inject_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;
  localparam int WDOG = 8;
`ifdef NOC_ARB_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic           noc_clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_flit;
  logic [N-1:0]   req_is_header;
  logic [N-1:0]   req_is_tail;
  logic           Noc_sender_valid;
  logic           Noc_sender_ready;
  logic [W-1:0]   Noc_sender_flit;
  logic           Noc_sender_VCready;
  logic           Noc_sender_is_header;
  logic           Noc_sender_is_tail;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           wdog_err;

  always #5 noc_clk = ~noc_clk;

  noc_inject_arbiter #(
    .NUM_REQ  (N),
    .DATA_W   (W),
    .ID_W     (IDW),
    .WDOG_CYC (WDOG)
  ) dut (
    .noc_clk              (noc_clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_flit             (req_flit),
    .req_is_header        (req_is_header),
    .req_is_tail          (req_is_tail),
    .Noc_sender_valid     (Noc_sender_valid),
    .Noc_sender_ready     (Noc_sender_ready),
    .Noc_sender_flit      (Noc_sender_flit),
    .Noc_sender_VCready   (Noc_sender_VCready),
    .Noc_sender_is_header (Noc_sender_is_header),
    .Noc_sender_is_tail   (Noc_sender_is_tail),
    .grant_id             (grant_id),
    .busy                 (busy),
    .wdog_err             (wdog_err)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         h;
    logic         t;
  } flit_t;

  // Reference model: per-source packet queues, current owner (-1 = none), last owner, stall count.
  flit_t        src_q [N][$];
  logic [N-1:0] gate;
  bit           vc;
  bit           srdy;
  int           owner;
  int           last;
  int           stall;
  bit           wexp;
  int           grant_log [$];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic add_pkt(input int s, input int len);
    flit_t f;
    for (int k = 0; k < len; k++) begin
      f.d = W'($urandom);
      f.h = (k == 0);
      f.t = (k == len - 1);
      src_q[s].push_back(f);
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < N; i++) n += src_q[i].size();
    return n;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && gate[i]) begin
        req_valid[i]         = 1'b1;
        req_flit[i*W +: W]   = src_q[i][0].d;
        req_is_header[i]     = src_q[i][0].h;
        req_is_tail[i]       = src_q[i][0].t;
      end else begin
        req_valid[i]         = 1'b0;
        req_flit[i*W +: W]   = '0;
        req_is_header[i]     = 1'b0;
        req_is_tail[i]       = 1'b0;
      end
    end
    Noc_sender_ready   = srdy;
    Noc_sender_VCready = vc;
  endtask

  // One clock: drive at negedge, check outputs 1 ns later, advance the model, move to next negedge.
  task automatic step();
    logic [N-1:0] cand;
    flit_t        f;
    drive();
    #1;
    if (owner < 0) begin
      chk("busy_idle", 64'(busy), 0);
      chk("snd_valid_idle", 64'(Noc_sender_valid), 0);
      chk("snd_flit_idle", 64'(Noc_sender_flit), 0);
      chk("snd_hdr_idle", 64'(Noc_sender_is_header), 0);
      chk("snd_tail_idle", 64'(Noc_sender_is_tail), 0);
      chk("req_ready_idle", 64'(req_ready), 0);
    end else begin
      chk("busy_lock", 64'(busy), 1);
      chk("grant_id", 64'(grant_id), 64'(owner));
      chk("snd_valid", 64'(Noc_sender_valid), 64'(req_valid[owner]));
      chk("snd_flit", 64'(Noc_sender_flit), 64'(req_flit[owner*W +: W]));
      chk("snd_hdr", 64'(Noc_sender_is_header), 64'(req_is_header[owner]));
      chk("snd_tail", 64'(Noc_sender_is_tail), 64'(req_is_tail[owner]));
      chk("req_ready", 64'(req_ready), 64'(N'(srdy) << owner));
    end
    chk("wdog_err", 64'(wdog_err), 64'(wexp));

    if (owner < 0) begin
      stall = 0;
      cand  = req_valid & req_is_header;
      if (vc) begin
        for (int k = 1; k <= N; k++) begin
          if (owner < 0 && cand[(last + k) % N]) begin
            owner = (last + k) % N;
            grant_log.push_back(owner);
          end
        end
      end
    end else if (req_valid[owner] && srdy) begin
      stall = 0;
      f = src_q[owner].pop_front();
      if (f.t) begin
        last  = owner;
        owner = -1;
      end
    end else begin
      stall++;
      if (WD_ON && stall == WDOG) wexp = 1'b1;
    end
    @(posedge noc_clk);
    @(negedge noc_clk);
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while ((pending() > 0 || owner >= 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(pending()), 0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive();
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_grant_id", 64'(grant_id), 0);
    chk("rst_snd_valid", 64'(Noc_sender_valid), 0);
    chk("rst_snd_flit", 64'(Noc_sender_flit), 0);
    chk("rst_snd_marks", 64'({Noc_sender_is_header, Noc_sender_is_tail}), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_wdog", 64'(wdog_err), 0);
    owner = -1;
    last  = N - 1;
    stall = 0;
    wexp  = 1'b0;
    @(posedge noc_clk);
    @(negedge noc_clk);
    rst = 1'b0;
  endtask

  initial begin
    bit [8:0] bp_pat;
    int       n;
    gate = '1;
    vc   = 1'b1;
    srdy = 1'b1;
    req_valid = '0; req_flit = '0; req_is_header = '0; req_is_tail = '0;
    Noc_sender_ready = 1'b0; Noc_sender_VCready = 1'b0;
    do_reset();

    // Single 3-flit packet from source 1
    grant_log.delete();
    add_pkt(1, 3);
    run_until_empty(50);
    chk("single_grant", 64'(grant_log[0]), 1);
    chk("single_count", 64'(grant_log.size()), 1);

    // Contention: four headers together after reset
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) add_pkt(i, 1 + int'($urandom % 4));
    run_until_empty(100);
    chk("cont_count", 64'(grant_log.size()), 4);
    for (int k = 0; k < N; k++) chk("cont_order", 64'(grant_log[k]), 64'(k));

    // Credit gating
    vc = 1'b0;
    add_pkt(2, 2);
    repeat (5) step();
    chk("credit_hold", 64'(busy), 0);
    vc = 1'b1;
    step();
    chk("credit_grant_busy", 64'(busy), 1);
    chk("credit_grant_id", 64'(grant_id), 2);
    run_until_empty(50);

    // Backpressure mid-packet
    add_pkt(0, 4);
    bp_pat = 9'b111110011;
    for (int k = 0; k < 9; k++) begin
      srdy = bp_pat[k];
      step();
    end
    srdy = 1'b1;
    run_until_empty(50);

    // Owner stalls in LOCK long enough to trip the watchdog (when built)
    add_pkt(2, 3);
    step();
    gate[2] = 1'b0;
    repeat (WDOG) step();
    chk("wdog_set", 64'(wdog_err), 64'(WD_ON));
    gate = '1;
    run_until_empty(50);
    chk("wdog_sticky", 64'(wdog_err), 64'(WD_ON));

    // 1-flit packet on source 3, then reset in the middle of a 4-flit packet on source 1
    add_pkt(3, 1);
    step();
    step();
    chk("oneflit_done", 64'(src_q[3].size()), 0);
    add_pkt(1, 4);
    n = 0;
    while (src_q[1].size() > 2 && n < 20) begin
      step();
      n++;
    end
    chk("midpkt_reached", 64'(src_q[1].size()), 2);
    do_reset();
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && ($urandom % 6) == 0) add_pkt(i, 1 + int'($urandom % 4));
        gate[i] = (($urandom % 5) != 0);
      end
      vc   = (($urandom % 4) != 0);
      srdy = (($urandom % 3) != 0);
      step();
    end
    gate = '1;
    vc   = 1'b1;
    srdy = 1'b1;
    run_until_empty(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
